// File: rtl/iic_target_regs.sv
// iic_target_regs: I2C target that answers DEV_ADDR and exposes NUM_REGS
// byte registers using a pointer-then-data protocol on an open-drain pad.
// Ports: clk, reset (async, high); scl_in/sda_in pad levels; sda_oe pulls
// SDA low; regs_flat register contents; wr_strobe/wr_addr/wr_data write
// event; busy from an address match until STOP.
module iic_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic [NUM_REGS*8-1:0]       regs_flat,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        busy
);

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(FILT_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE,
    WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_e;

  // Input path: index 1 = SCL, index 0 = SDA.
  logic [1:0]    pad;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    filt_q, prev_q;
  logic [CW-1:0] cnt_q [2];

  assign pad = {scl_in, sda_in};

  // Filtered level flips once FILT_LEN consecutive synced
  // samples disagree with it; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= pad;
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_TOP) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  logic scl_f, sda_f;
  logic scl_rise, scl_fall;
  logic start_c, stop_c;

  assign scl_f    = filt_q[1];
  assign sda_f    = filt_q[0];
  assign scl_rise = scl_f & ~prev_q[1];
  assign scl_fall = ~scl_f & prev_q[1];
  assign start_c  = scl_f & prev_q[1] & ~sda_f & prev_q[0];
  assign stop_c   = scl_f & prev_q[1] & sda_f & ~prev_q[0];

  // Protocol state and datapath.
  state_e        state_q, state_d;
  logic [6:0]    shreg_q, shreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          first_q, first_d;
  logic          sda_oe_q, sda_oe_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          reg_we;
  logic [7:0]    regs_q [NUM_REGS];

  logic [7:0] byte_in;
  logic [7:0] rd_byte;
  logic       last_bit;
  logic       phase;
  logic       addr_hit;

  assign byte_in  = {shreg_q, sda_f};
  assign rd_byte  = regs_q[ptr_q];
  assign last_bit = (bit_cnt_q == 3'd7);
  // In ACK states bit_cnt[0] marks "ACK clock in progress".
  assign phase    = bit_cnt_q[0];
  assign addr_hit = (byte_in[7:1] == DEV_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_c) begin
      state_d = ADDR;
    end else if (stop_c) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        ADDR:
          if (scl_rise && last_bit)
            state_d = addr_hit ? ADDR_ACK : IGNORE;
        ADDR_ACK:
          if (scl_fall && phase)
            state_d = rw_q ? RD_BYTE : WR_BYTE;
        WR_BYTE:
          if (scl_rise && last_bit) state_d = WR_ACK;
        WR_ACK:
          if (scl_fall && phase) state_d = WR_BYTE;
        RD_BYTE:
          if (scl_fall && last_bit) state_d = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_f)
            state_d = IGNORE;
          else if (scl_fall && phase)
            state_d = RD_BYTE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    first_d     = first_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    reg_we      = 1'b0;
    if (start_c || stop_c) begin
      // Bus condition aborts any byte in flight.
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      if (stop_c) busy_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR:
          if (scl_rise) begin
            shreg_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              rw_d = sda_f;
              if (addr_hit) begin
                busy_d  = 1'b1;
                first_d = 1'b1;
              end
            end
          end
        ADDR_ACK, WR_ACK:
          if (scl_fall) begin
            if (!phase) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 3'd1;
            end else begin
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
              if (state_q == ADDR_ACK && rw_q) begin
                // Bit 7 goes on the bus now; the rest waits in shreg.
                shreg_d  = rd_byte[6:0];
                sda_oe_d = ~rd_byte[7];
                ptr_d    = ptr_q + PTR_ONE;
              end
            end
          end
        WR_BYTE:
          if (scl_rise) begin
            shreg_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              if (first_q) begin
                ptr_d   = byte_in[AW-1:0];
                first_d = 1'b0;
              end else begin
                reg_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = byte_in;
                ptr_d       = ptr_q + PTR_ONE;
              end
            end
          end
        RD_BYTE:
          if (scl_fall) begin
            shreg_d   = {shreg_q[5:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            sda_oe_d  = last_bit ? 1'b0 : ~shreg_q[6];
          end
        RD_ACK: begin
          if (scl_rise && !sda_f) begin
            bit_cnt_d = 3'd1;
          end else if (scl_fall && phase) begin
            bit_cnt_d = '0;
            shreg_d   = rd_byte[6:0];
            sda_oe_d  = ~rd_byte[7];
            ptr_d     = ptr_q + PTR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      if (reg_we) regs_q[wr_addr_d] <= wr_data_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

  assign sda_oe    = sda_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_iic_target_regs.sv
// tb_iic_target_regs: directed I2C master driving iic_target_regs
// through writes, wrapped reads, mismatch, abort, glitch and reset.
module tb_iic_target_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         m_scl, m_sda;
  logic         sda_bus;
  logic         sda_oe, wr_strobe, busy;
  logic [127:0] regs_flat;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;

  assign sda_bus = m_sda & ~sda_oe;

  iic_target_regs #(
    .DEV_ADDR(7'h50),
    .NUM_REGS(16),
    .FILT_LEN(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (m_scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .regs_flat(regs_flat),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int         st_n = 0;
  int         oe_cnt = 0;
  int         busy_cnt = 0;
  logic [3:0] st_addr [32];
  logic [7:0] st_data [32];

  always @(negedge clk) begin
    if (wr_strobe && st_n < 32) begin
      st_addr[st_n] = wr_addr;
      st_data[st_n] = wr_data;
      st_n = st_n + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock; g adds a 1-clk high glitch in the low phase
  // and a 1-clk low glitch in the high phase.
  task automatic bit_x(input logic b, input logic g, output logic rb);
    w(6);
    m_sda = b;
    if (g) begin
      w(2); m_scl = 1'b1; w(1); m_scl = 1'b0; w(3);
    end else begin
      w(6);
    end
    m_scl = 1'b1;
    if (g) begin
      w(4); m_scl = 1'b0; w(1); m_scl = 1'b1; w(4);
    end else begin
      w(9);
    end
    rb = sda_bus;
    w(3);
    m_scl = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] d, input logic g,
                       output logic ack);
    logic rb;
    for (int i = 7; i >= 0; i--) bit_x(d[i], g, rb);
    bit_x(1'b1, 1'b0, ack);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic rb;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, 1'b0, rb);
      d[i] = rb;
    end
    bit_x(nack, 1'b0, rb);
  endtask

  task automatic bus_start();
    w(3);
    m_sda = 1'b1;
    w(6);
    m_scl = 1'b1;
    w(12);
    m_sda = 1'b0;
    w(12);
    m_scl = 1'b0;
  endtask

  task automatic bus_stop();
    w(6);
    m_sda = 1'b0;
    w(6);
    m_scl = 1'b1;
    w(12);
    m_sda = 1'b1;
    w(12);
  endtask

  initial begin
    logic         ack;
    logic [7:0]   rd;
    logic [7:0]   part;
    logic [127:0] exp_regs;
    int           st0, oe0, busy0;

    reset = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    exp_regs = '0;
    w(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_regs", regs_flat, exp_regs);
    reset = 1'b0;
    w(10);

    // Pointer 3, then 0x5A, 0xC3.
    bus_start();
    wbyte(8'hA0, 1'b0, ack); chk("t1_addr_ack", ack, 0);
    chk("t1_busy_hi", busy, 1);
    wbyte(8'h03, 1'b0, ack); chk("t1_ptr_ack", ack, 0);
    wbyte(8'h5A, 1'b0, ack); chk("t1_d0_ack", ack, 0);
    wbyte(8'hC3, 1'b0, ack); chk("t1_d1_ack", ack, 0);
    bus_stop();
    chk("t1_busy_lo", busy, 0);
    chk("t1_nstrobe", st_n, 2);
    chk("t1_waddr0", st_addr[0], 4'h3);
    chk("t1_wdata0", st_data[0], 8'h5A);
    chk("t1_waddr1", st_addr[1], 4'h4);
    chk("t1_wdata1", st_data[1], 8'hC3);
    exp_regs[3*8 +: 8] = 8'h5A;
    exp_regs[4*8 +: 8] = 8'hC3;
    chk("t1_regs", regs_flat, exp_regs);

    // Write 0x96 to reg15 and 0x3C to reg0 (wrapping pointer).
    bus_start();
    wbyte(8'hA0, 1'b0, ack);
    wbyte(8'h0F, 1'b0, ack);
    wbyte(8'h96, 1'b0, ack);
    wbyte(8'h3C, 1'b0, ack); chk("t2_wrap_ack", ack, 0);
    bus_stop();
    chk("t2_nstrobe", st_n, 4);
    chk("t2_waddr2", st_addr[2], 4'hF);
    chk("t2_waddr3", st_addr[3], 4'h0);
    chk("t2_wdata3", st_data[3], 8'h3C);
    exp_regs[15*8 +: 8] = 8'h96;
    exp_regs[0 +: 8] = 8'h3C;

    // Pointer 0x0F, repeated START, read reg15 then reg0.
    bus_start();
    wbyte(8'hA0, 1'b0, ack);
    wbyte(8'h0F, 1'b0, ack);
    bus_start();
    wbyte(8'hA1, 1'b0, ack); chk("t2_rd_addr_ack", ack, 0);
    rbyte(1'b0, rd); chk("t2_rd_reg15", rd, 8'h96);
    rbyte(1'b1, rd); chk("t2_rd_reg0", rd, 8'h3C);
    w(8);
    chk("t2_oe_after_nack", sda_oe, 0);
    chk("t2_no_rd_strobe", st_n, 4);
    bus_stop();
    chk("t2_regs", regs_flat, exp_regs);

    // Address mismatch.
    st0 = st_n; oe0 = oe_cnt; busy0 = busy_cnt;
    bus_start();
    wbyte(8'hA4, 1'b0, ack); chk("t3_addr_nack", ack, 1);
    wbyte(8'h11, 1'b0, ack); chk("t3_data_nack", ack, 1);
    bus_stop();
    chk("t3_oe_never", oe_cnt, oe0);
    chk("t3_busy_never", busy_cnt, busy0);
    chk("t3_no_strobe", st_n, st0);

    // STOP after 5 bits of a data byte.
    bus_start();
    wbyte(8'hA0, 1'b0, ack);
    wbyte(8'h02, 1'b0, ack);
    part = 8'hE7;
    for (int i = 7; i >= 3; i--) bit_x(part[i], 1'b0, ack);
    bus_stop();
    chk("t4_no_strobe", st_n, st0);
    chk("t4_regs_kept", regs_flat, exp_regs);
    bus_start();
    wbyte(8'hA0, 1'b0, ack); chk("t4_next_ack", ack, 0);
    wbyte(8'h07, 1'b0, ack);
    wbyte(8'h81, 1'b0, ack); chk("t4_data_ack", ack, 0);
    bus_stop();
    chk("t4_nstrobe", st_n, st0 + 1);
    chk("t4_waddr", st_addr[4], 4'h7);
    chk("t4_wdata", st_data[4], 8'h81);
    exp_regs[7*8 +: 8] = 8'h81;
    chk("t4_regs", regs_flat, exp_regs);

    // Data byte with 1-clk SCL glitches on every bit.
    bus_start();
    wbyte(8'hA0, 1'b0, ack);
    wbyte(8'h05, 1'b0, ack);
    wbyte(8'h6B, 1'b1, ack); chk("t5_glitch_ack", ack, 0);
    bus_stop();
    chk("t5_nstrobe", st_n, 6);
    chk("t5_waddr", st_addr[5], 4'h5);
    chk("t5_wdata", st_data[5], 8'h6B);
    exp_regs[5*8 +: 8] = 8'h6B;
    chk("t5_regs", regs_flat, exp_regs);

    // Reset while driving bit 7 (reg6 = 0) of a read.
    bus_start();
    wbyte(8'hA1, 1'b0, ack); chk("t6_addr_ack", ack, 0);
    w(8);
    chk("t6_rd_drive", sda_oe, 1);
    reset = 1'b1;
    #1;
    chk("t6_oe_async", sda_oe, 0);
    w(2);
    exp_regs = '0;
    chk("t6_regs_clr", regs_flat, exp_regs);
    chk("t6_busy_clr", busy, 0);
    chk("t6_waddr_clr", wr_addr, 0);
    chk("t6_wdata_clr", wr_data, 0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    w(4);
    reset = 1'b0;
    w(10);

    bus_start();
    wbyte(8'hA0, 1'b0, ack); chk("t7_addr_ack", ack, 0);
    wbyte(8'h01, 1'b0, ack);
    wbyte(8'h77, 1'b0, ack); chk("t7_data_ack", ack, 0);
    bus_stop();
    chk("t7_nstrobe", st_n, 7);
    chk("t7_waddr", st_addr[6], 4'h1);
    chk("t7_wdata", st_data[6], 8'h77);
    bus_start();
    wbyte(8'hA0, 1'b0, ack);
    wbyte(8'h01, 1'b0, ack);
    bus_start();
    wbyte(8'hA1, 1'b0, ack);
    rbyte(1'b1, rd); chk("t7_rd_reg1", rd, 8'h77);
    bus_stop();
    exp_regs[1*8 +: 8] = 8'h77;
    chk("t7_regs", regs_flat, exp_regs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
